// File: rtl/secuenciador_tiempos.sv
// secuenciador_tiempos: bus-cycle step sequencer for an RTC timing-signal generator.
//
// Accepts one of three transaction requests (init > write > read priority) while idle.
// It then steps estado through 0..11, holding each value for TICKS clocks, and waits
// in WAIT_LISTO for listo from the downstream generator. A one-cycle DONE step follows
// (fin pulse, plus error_to if listo never came within TIMEOUT clocks).
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-low
//   req_inicio      in   init transaction request
//   req_escribir    in   write transaction request
//   req_leer        in   read transaction request
//   modo[2:0]       in   read sub-mode, latched when a read is accepted
//   listo           in   completion flag from the timing-signal generator
//   estado[3:0]     out  bus-cycle step index 0..11
//   Estado_m[2:0]   out  latched modo (0 for init/write)
//   enable_inicio   out  high for the whole init transaction
//   enable_escribir out  high for the whole write transaction
//   enable_leer     out  high for the whole read transaction
//   ocupado         out  transaction in progress (RUN, WAIT_LISTO, DONE)
//   fin             out  one-cycle completion pulse
//   error_to        out  one-cycle listo-timeout pulse, coincident with fin
module secuenciador_tiempos #(
  parameter int unsigned TICKS   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_inicio,
  input  logic       req_escribir,
  input  logic       req_leer,
  input  logic [2:0] modo,
  input  logic       listo,
  output logic [3:0] estado,
  output logic [2:0] Estado_m,
  output logic       enable_inicio,
  output logic       enable_escribir,
  output logic       enable_leer,
  output logic       ocupado,
  output logic       fin,
  output logic       error_to
);

  localparam int unsigned ToW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  TickLast = 4'(TICKS - 1);
  localparam logic [3:0]  LastStep = 4'd11;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StWaitListo, StDone} state_e;

  state_e         r_state, w_state_d;
  logic [3:0]     r_estado, w_estado_d;
  logic [3:0]     r_tick, w_tick_d;
  logic [ToW-1:0] r_to, w_to_d;
  logic [2:0]     r_modo, w_modo_d;
  logic           r_en_ini, w_en_ini_d;
  logic           r_en_esc, w_en_esc_d;
  logic           r_en_leer, w_en_leer_d;
  logic           r_error_to, w_error_to_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_estado   <= 4'd0;
      r_tick     <= 4'd0;
      r_to       <= '0;
      r_modo     <= 3'd0;
      r_en_ini   <= 1'b0;
      r_en_esc   <= 1'b0;
      r_en_leer  <= 1'b0;
      r_error_to <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_estado   <= w_estado_d;
      r_tick     <= w_tick_d;
      r_to       <= w_to_d;
      r_modo     <= w_modo_d;
      r_en_ini   <= w_en_ini_d;
      r_en_esc   <= w_en_esc_d;
      r_en_leer  <= w_en_leer_d;
      r_error_to <= w_error_to_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_estado_d   = r_estado;
    w_tick_d     = r_tick;
    w_to_d       = r_to;
    w_modo_d     = r_modo;
    w_en_ini_d   = r_en_ini;
    w_en_esc_d   = r_en_esc;
    w_en_leer_d  = r_en_leer;
    w_error_to_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (req_inicio || req_escribir || req_leer) begin
          w_state_d  = StRun;
          w_estado_d = 4'd0;
          w_tick_d   = 4'd0;
          w_modo_d   = 3'd0;
          // Priority select: only the winner's enable is raised, the rest are dropped.
          if (req_inicio) begin
            w_en_ini_d = 1'b1;
          end else if (req_escribir) begin
            w_en_esc_d = 1'b1;
          end else begin
            w_en_leer_d = 1'b1;
            w_modo_d    = modo;
          end
        end
      end

      StRun: begin
        if (r_tick == TickLast) begin
          w_tick_d = 4'd0;
          // Step 11 gets its full TICKS hold like every other step, then stays at 11
          // while waiting for listo, so accept-to-fin is 1 + 12*TICKS + L + 1.
          if (r_estado == LastStep) begin
            w_state_d = StWaitListo;
            w_to_d    = '0;
          end else begin
            w_estado_d = r_estado + 4'd1;
          end
        end else begin
          w_tick_d = r_tick + 4'd1;
        end
      end

      StWaitListo: begin
        // listo wins over a timeout expiring in the same cycle.
        if (listo || (r_to == ToLast)) begin
          w_state_d    = StDone;
          w_error_to_d = ~listo;
          w_estado_d   = 4'd0;
          w_modo_d     = 3'd0;
          w_en_ini_d   = 1'b0;
          w_en_esc_d   = 1'b0;
          w_en_leer_d  = 1'b0;
          w_to_d       = '0;
        end else begin
          w_to_d = r_to + 1'b1;
        end
      end

      StDone: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign estado          = r_estado;
  assign Estado_m        = r_modo;
  assign enable_inicio   = r_en_ini;
  assign enable_escribir = r_en_esc;
  assign enable_leer     = r_en_leer;
  assign ocupado         = (r_state != StIdle);
  assign fin             = (r_state == StDone);
  assign error_to        = r_error_to;

endmodule

// File: tb/tb_secuenciador_tiempos.sv
// Directed bench for secuenciador_tiempos with TICKS=4, TIMEOUT=15.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Cycle numbering inside a transaction: cycle c is the state after the c-th edge
// following the accept edge (cycle 1 = first RUN cycle, estado=0).
module tb_secuenciador_tiempos;

  logic       clk;
  logic       reset;
  logic       req_inicio;
  logic       req_escribir;
  logic       req_leer;
  logic [2:0] modo;
  logic       listo;
  logic [3:0] estado;
  logic [2:0] Estado_m;
  logic       enable_inicio;
  logic       enable_escribir;
  logic       enable_leer;
  logic       ocupado;
  logic       fin;
  logic       error_to;

  int n_checks;
  int n_fail;

  // {ocupado, fin, error_to, enable_inicio, enable_escribir, enable_leer, Estado_m, estado}
  logic [12:0] w_obs;
  assign w_obs = {ocupado, fin, error_to, enable_inicio, enable_escribir, enable_leer,
                  Estado_m, estado};

  secuenciador_tiempos #(
    .TICKS  (4),
    .TIMEOUT(15)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_inicio     (req_inicio),
    .req_escribir   (req_escribir),
    .req_leer       (req_leer),
    .modo           (modo),
    .listo          (listo),
    .estado         (estado),
    .Estado_m       (Estado_m),
    .enable_inicio  (enable_inicio),
    .enable_escribir(enable_escribir),
    .enable_leer    (enable_leer),
    .ocupado        (ocupado),
    .fin            (fin),
    .error_to       (error_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_vec(input logic ocu, input logic fi, input logic er,
                                          input logic ei, input logic ee, input logic el,
                                          input logic [2:0] m, input logic [3:0] e);
    return {ocu, fi, er, ei, ee, el, m, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_inicio = 1'b1;
    req_escribir = 1'b1;
    req_leer = 1'b1;
    modo = 3'd7;
    listo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (w_obs !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_hold i=%0d: got %h expected %h", i, w_obs, 13'd0);
      end
    end
    req_inicio = 1'b0;
    req_escribir = 1'b0;
    req_leer = 1'b0;
    modo = 3'd0;
    reset = 1'b1;
    step();
    n_checks++;
    if (w_obs !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", w_obs, 13'd0);
    end
  endtask

  task automatic test_write();
    logic [12:0] e;
    req_escribir = 1'b1;
    step();
    req_escribir = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'((c - 1) / 4));
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL write_run c=%0d: got %h expected %h", c, w_obs, e);
      end
      step();
    end
    // Cycle 49: first WAIT_LISTO cycle, listo returned here (L = 1).
    listo = 1'b1;
    e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd11);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL write_wait: got %h expected %h", w_obs, e);
    end
    step();
    listo = 1'b0;
    // Cycle 50: DONE, 50 edges after accept.
    e = exp_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL write_done: got %h expected %h", w_obs, e);
    end
    step();
    n_checks++;
    if (w_obs !== 13'd0) begin
      n_fail++;
      $display("FAIL write_idle: got %h expected %h", w_obs, 13'd0);
    end
  endtask

  task automatic test_read_modo();
    logic [12:0] e;
    modo = 3'd1;
    req_leer = 1'b1;
    step();
    req_leer = 1'b0;
    modo = 3'd5;  // must not disturb the latched value
    for (int c = 1; c <= 48; c++) begin
      e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'((c - 1) / 4));
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL read_run c=%0d: got %h expected %h", c, w_obs, e);
      end
      step();
    end
    // Cycles 49..51 in WAIT_LISTO, listo on the third (L = 3).
    for (int w = 0; w < 3; w++) begin
      listo = (w == 2);
      e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd11);
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL read_wait w=%0d: got %h expected %h", w, w_obs, e);
      end
      step();
    end
    listo = 1'b0;
    e = exp_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL read_done: got %h expected %h", w_obs, e);
    end
    step();
    n_checks++;
    if (w_obs !== 13'd0) begin
      n_fail++;
      $display("FAIL read_idle_modo: got %h expected %h", w_obs, 13'd0);
    end
    modo = 3'd0;
  endtask

  task automatic test_priority();
    logic [12:0] e;
    req_inicio = 1'b1;
    req_escribir = 1'b1;
    req_leer = 1'b1;
    modo = 3'd7;
    step();
    req_inicio = 1'b0;
    req_escribir = 1'b0;
    req_leer = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      e = exp_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'((c - 1) / 4));
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL prio_run c=%0d: got %h expected %h", c, w_obs, e);
      end
      step();
    end
    listo = 1'b1;
    step();
    listo = 1'b0;
    e = exp_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL prio_done: got %h expected %h", w_obs, e);
    end
    // Dropped write/read requests must not start later.
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (w_obs !== 13'd0) begin
        n_fail++;
        $display("FAIL prio_no_followup i=%0d: got %h expected %h", i, w_obs, 13'd0);
      end
    end
    modo = 3'd0;
  endtask

  task automatic test_timeout();
    logic [12:0] e;
    req_escribir = 1'b1;
    step();
    req_escribir = 1'b0;
    for (int c = 1; c <= 48; c++) step();
    // Cycles 49..63: 15 WAIT_LISTO cycles without listo.
    for (int w = 0; w < 15; w++) begin
      e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd11);
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL timeout_wait w=%0d: got %h expected %h", w, w_obs, e);
      end
      step();
    end
    e = exp_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL timeout_done: got %h expected %h", w_obs, e);
    end
    step();
    n_checks++;
    if (w_obs !== 13'd0) begin
      n_fail++;
      $display("FAIL timeout_idle: got %h expected %h", w_obs, 13'd0);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    req_escribir = 1'b1;
    step();
    req_escribir = 1'b0;
    for (int c = 1; c < 25; c++) step();
    // Cycle 25: first cycle with estado = 6.
    e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd6);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL midrst_pre: got %h expected %h", w_obs, e);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_checks++;
    if (w_obs !== 13'd0) begin
      n_fail++;
      $display("FAIL midrst_abort: got %h expected %h", w_obs, 13'd0);
    end
    step();
    n_checks++;
    if (w_obs !== 13'd0) begin
      n_fail++;
      $display("FAIL midrst_no_fin: got %h expected %h", w_obs, 13'd0);
    end
    req_escribir = 1'b1;
    step();
    req_escribir = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'((c - 1) / 4));
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL midrst_restart c=%0d: got %h expected %h", c, w_obs, e);
      end
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    req_escribir = 1'b1;
    step();
    req_escribir = 1'b0;
    req_leer = 1'b1;  // held high for the rest of the test
    for (int c = 1; c <= 48; c++) begin
      e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'((c - 1) / 4));
      n_checks++;
      if (w_obs !== e) begin
        n_fail++;
        $display("FAIL b2b_run c=%0d: got %h expected %h", c, w_obs, e);
      end
      step();
    end
    listo = 1'b1;
    step();
    listo = 1'b0;
    e = exp_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL b2b_done: got %h expected %h", w_obs, e);
    end
    step();
    // Read sampled in DONE is ignored: one IDLE cycle appears.
    n_checks++;
    if (w_obs !== 13'd0) begin
      n_fail++;
      $display("FAIL b2b_idle: got %h expected %h", w_obs, 13'd0);
    end
    step();
    req_leer = 1'b0;
    e = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0);
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL b2b_accept: got %h expected %h", w_obs, e);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    req_inicio = 1'b0;
    req_escribir = 1'b0;
    req_leer = 1'b0;
    modo = 3'd0;
    listo = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read_modo();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
